rca_nibble_sequencer: RTL and testbench

- Performs one wide add (NIBBLES*4 bits plus carry-in) by sequencing a single external 4-bit ripple-carry adder one nibble per clock, least-significant nibble first.
- The carry is chained between cycles. The wide result is presented on a valid/ready output.
- Sits between the requester and the shared 4-bit adder instance. The adder stays purely combinational, and this block owns all state.

---
 rtl/rca_nibble_sequencer_if.sv | 33 +++
 rtl/rca_nibble_sequencer.sv | 97 +++++++++
 tb/tb_rca_nibble_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rca_nibble_sequencer_if.sv
// Request, result and shared-adder signals of the nibble sequencer.
// The slave modport is the sequencer's view; master is the requester/adder side.
interface rca_nibble_sequencer_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;

   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [4:0]   add_s;

   logic         out_valid;
   logic         out_ready;
   logic [W:0]   out_sum;
   logic         busy;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready, add_s,
      input  in_ready, out_valid, out_sum, busy, add_a, add_b, add_cin
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready, add_s,
      output in_ready, out_valid, out_sum, busy, add_a, add_b, add_cin
   );
endinterface

// File: rtl/rca_nibble_sequencer.sv
// Wide add by stepping an external 4-bit adder one nibble per clock, LS nibble first.
// Result valid NIBBLES cycles after accept; holds in DONE until out_ready, one IDLE cycle before next accept.
module rca_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   rca_nibble_sequencer_if.slave  io
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     opa;
   logic [W-1:0]     opb;
   logic [W:0]       sum;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [3:0]       add_a_r;
   logic [3:0]       add_b_r;
   logic             add_cin_r;

   assign io.in_ready  = in_ready_r;
   assign io.out_valid = out_valid_r;
   assign io.busy      = busy_r;
   assign io.out_sum   = sum;
   assign io.add_a     = add_a_r;
   assign io.add_b     = add_b_r;
   assign io.add_cin   = add_cin_r;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         opa         <= '0;
         opb         <= '0;
         sum         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         add_a_r     <= '0;
         add_b_r     <= '0;
         add_cin_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.in_valid) begin
                  opa        <= io.in_a;
                  opb        <= io.in_b;
                  carry      <= io.in_cin;
                  idx        <= '0;
                  add_a_r    <= io.in_a[3:0];
                  add_b_r    <= io.in_b[3:0];
                  add_cin_r  <= io.in_cin;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               sum[4*idx +: 4] <= io.add_s[3:0];
               carry           <= io.add_s[4];
               if (idx == LAST) begin
                  // Adder inputs go quiet as soon as the last slice is captured.
                  sum[W]      <= io.add_s[4];
                  add_a_r     <= '0;
                  add_b_r     <= '0;
                  add_cin_r   <= 1'b0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx       <= idx + 1'b1;
                  add_a_r   <= opa[4*(int'(idx) + 1) +: 4];
                  add_b_r   <= opb[4*(int'(idx) + 1) +: 4];
                  add_cin_r <= io.add_s[4];
               end
            end
            DONE: begin
               if (io.out_ready) begin
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed and random checks of the nibble sequencer with a behavioural 4-bit adder.
module tb_rca_nibble_sequencer;
   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accepts = 0;
   int   last_acc = 0;

   rca_nibble_sequencer_if #(.NIBBLES(4)) ifc ();

   rca_nibble_sequencer #(.NIBBLES(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (ifc.slave)
   );

   assign ifc.add_s = {1'b0, ifc.add_a} + {1'b0, ifc.add_b} + {4'b0, ifc.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (reset_n && ifc.in_valid && ifc.in_ready) begin
         accepts++;
         last_acc = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
      $fatal(1);
   end

   task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic cin, output int ok);
      ifc.in_a = a;
      ifc.in_b = b;
      ifc.in_cin = cin;
      ifc.in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && ok == 0; i++) begin
         if (ifc.in_ready === 1'b1) ok = 1;
         @(negedge clk);
      end
      ifc.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (ifc.out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.out_ready = 1'b0;
      ifc.in_a = '0;
      ifc.in_b = '0;
      ifc.in_cin = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
      checks++; if ({ifc.add_a, ifc.add_b, ifc.add_cin} !== 9'h0) begin errors++; $display("FAIL reset_adder_in: got %h/%h/%b want 0/0/0", ifc.add_a, ifc.add_b, ifc.add_cin); end
      checks++; if (ifc.out_sum !== 17'h0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", ifc.out_sum); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ripple;
      logic [3:0] exp_b [4];
      logic       exp_c [4];
      int ok;
      exp_b = '{4'h1, 4'h0, 4'h0, 4'h0};
      exp_c = '{1'b0, 1'b1, 1'b1, 1'b1};
      ifc.out_ready = 1'b1;
      drive_req(16'hFFFF, 16'h0001, 1'b0, ok);
      checks++; if (ok != 1) begin errors++; $display("FAIL ripple_accept: got no accept want accept"); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (ifc.add_a !== 4'hF) begin errors++; $display("FAIL ripple_add_a[%0d]: got %h want F", k, ifc.add_a); end
         checks++; if (ifc.add_b !== exp_b[k]) begin errors++; $display("FAIL ripple_add_b[%0d]: got %h want %h", k, ifc.add_b, exp_b[k]); end
         checks++; if (ifc.add_cin !== exp_c[k]) begin errors++; $display("FAIL ripple_add_cin[%0d]: got %b want %b", k, ifc.add_cin, exp_c[k]); end
         checks++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin errors++; $display("FAIL ripple_run_flags[%0d]: got v%b r%b b%b want v0 r0 b1", k, ifc.out_valid, ifc.in_ready, ifc.busy); end
         @(negedge clk);
      end
      checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL ripple_latency: out_valid got %b want 1 at accept+4", ifc.out_valid); end
      checks++; if (ifc.out_sum !== 17'h10000) begin errors++; $display("FAIL ripple_sum: got %h want 10000", ifc.out_sum); end
      checks++; if (ifc.add_a !== 4'h0 || ifc.add_cin !== 1'b0) begin errors++; $display("FAIL ripple_quiet: got %h/%b want 0/0", ifc.add_a, ifc.add_cin); end
      @(negedge clk);
      checks++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin errors++; $display("FAIL ripple_return: got v%b r%b want v0 r1", ifc.out_valid, ifc.in_ready); end
   endtask

   task automatic test_carry_in;
      int ok, n;
      ifc.out_ready = 1'b0;
      drive_req(16'h1234, 16'h4321, 1'b1, ok);
      wait_out(n);
      checks++; if (ok != 1 || n != 4) begin errors++; $display("FAIL cin_latency: got ok %0d n %0d want 1 4", ok, n); end
      checks++; if (ifc.out_sum !== 17'h05556) begin errors++; $display("FAIL cin_sum: got %h want 05556", ifc.out_sum); end
      checks++; if (ifc.out_sum[16] !== 1'b0) begin errors++; $display("FAIL cin_carry: got %b want 0", ifc.out_sum[16]); end
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int ok, n, hs, acc0;
      ifc.out_ready = 1'b0;
      drive_req(16'hABCD, 16'h1111, 1'b0, ok);
      wait_out(n);
      checks++; if (ok != 1 || ifc.out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got ok %0d v %b want 1 1", ok, ifc.out_valid); end
      ifc.in_a = 16'h8000;
      ifc.in_b = 16'h8000;
      ifc.in_cin = 1'b1;
      ifc.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (ifc.out_valid !== 1'b1 || ifc.out_sum !== 17'h0BCDE) begin errors++; $display("FAIL bp_hold[%0d]: got v%b %h want v1 0bcde", i, ifc.out_valid, ifc.out_sum); end
         @(negedge clk);
      end
      ifc.out_ready = 1'b1;
      @(negedge clk);
      hs = cyc;
      acc0 = accepts;
      ifc.out_ready = 1'b0;
      checks++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v%b r%b want v0 r1", ifc.out_valid, ifc.in_ready); end
      repeat (6) @(negedge clk);
      ifc.in_valid = 1'b0;
      checks++; if (accepts != acc0 + 1) begin errors++; $display("FAIL bp_accept_count: got %0d want 1", accepts - acc0); end
      checks++; if (last_acc != hs + 1) begin errors++; $display("FAIL bp_accept_cycle: got %0d want %0d", last_acc, hs + 1); end
      wait_out(n);
      checks++; if (ifc.out_sum !== 17'h10001) begin errors++; $display("FAIL bp_second_sum: got %h want 10001", ifc.out_sum); end
      ifc.out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_midrun;
      int ok;
      logic seen;
      ifc.out_ready = 1'b1;
      drive_req(16'h1111, 16'h2222, 1'b0, ok);
      repeat (2) @(negedge clk);
      checks++; if (ifc.add_a !== 4'h1 || ifc.add_b !== 4'h2) begin errors++; $display("FAIL midrun_idx2: got %h/%h want 1/2", ifc.add_a, ifc.add_b); end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checks++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin errors++; $display("FAIL midrun_flags: got r%b v%b b%b want r1 v0 b0", ifc.in_ready, ifc.out_valid, ifc.busy); end
      checks++; if (ifc.add_a !== 4'h0 || ifc.out_sum !== 17'h0) begin errors++; $display("FAIL midrun_clear: got %h sum %h want 0 0", ifc.add_a, ifc.out_sum); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (ifc.out_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_output: got out_valid seen want none"); end
   endtask

   task automatic test_back_to_back;
      int ok, n, acc0, got;
      int at [3];
      ifc.out_ready = 1'b1;
      drive_req(16'h00FF, 16'h0F01, 1'b0, ok);
      ifc.in_a = 16'hFFFF;
      ifc.in_b = 16'hFFFF;
      ifc.in_cin = 1'b1;
      ifc.in_valid = 1'b1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      wait_out(n);
      checks++; if (ifc.out_sum !== 17'h01000) begin errors++; $display("FAIL b2b_ignored_pulse: got %h want 01000", ifc.out_sum); end
      @(negedge clk);
      acc0 = accepts;
      got = 0;
      ifc.in_a = 16'h0F0F;
      ifc.in_b = 16'h0101;
      ifc.in_cin = 1'b0;
      ifc.in_valid = 1'b1;
      for (int i = 0; i < 40 && got < 3; i++) begin
         @(negedge clk);
         if (accepts != acc0 + got) begin
            at[got] = last_acc;
            got++;
         end
      end
      ifc.in_valid = 1'b0;
      checks++; if (got != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", got); end
      checks++; if (got == 3 && (at[1] - at[0] != 6 || at[2] - at[1] != 6)) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d want 6,6", at[1] - at[0], at[2] - at[1]); end
      wait_out(n);
      checks++; if (ifc.out_sum !== 17'h01010) begin errors++; $display("FAIL b2b_sum: got %h want 01010", ifc.out_sum); end
      @(negedge clk);
   endtask

   task automatic test_random;
      int ok, done;
      logic [15:0] a, b;
      logic cin;
      logic [16:0] exp;
      for (int t = 0; t < 200; t++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom_range(0, 1));
         exp = {1'b0, a} + {1'b0, b} + {16'b0, cin};
         drive_req(a, b, cin, ok);
         checks++; if (ok != 1) begin errors++; $display("FAIL rand_accept[%0d]: got none want accept", t); end
         done = 0;
         for (int c = 0; c < 100 && done == 0; c++) begin
            checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL rand_busy[%0d]: got %b want 1", t, ifc.busy); end
            ifc.out_ready = 1'($urandom_range(0, 1));
            if (ifc.out_valid === 1'b1 && ifc.out_ready) begin
               checks++; if (ifc.out_sum !== exp) begin errors++; $display("FAIL rand_sum[%0d]: got %h want %h", t, ifc.out_sum, exp); end
               done = 1;
            end
            @(negedge clk);
         end
         ifc.out_ready = 1'b0;
         checks++; if (done != 1) begin errors++; $display("FAIL rand_timeout[%0d]: got no result want result", t); end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_ripple();
      test_carry_in();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
